// File: rtl/berzerk_input_ctrl.sv
// rtl/berzerk_input_ctrl.sv - PS/2 and joystick player-input front end for the Berzerk core
// Registers per-player controls, start lines, and a debounced fixed-width coin pulse.
module berzerk_input_ctrl #(
    parameter int COIN_PULSE = 400000,
    parameter int COIN_GAP   = 400000,
    parameter int CNT_W      = 20
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        cocktail,
    output logic        up1,
    output logic        down1,
    output logic        left1,
    output logic        right1,
    output logic        fire1,
    output logic        up2,
    output logic        down2,
    output logic        left2,
    output logic        right2,
    output logic        fire2,
    output logic        start1,
    output logic        start2,
    output logic        coin1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } coin_state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // key flag layout: [11:0] mirrors the control output order, [12] coin A, [13] coin B
    logic        primed_q, toggle_q;
    logic [13:0] keys_q, keys_d;
    logic [7:0]  joy0_q, joy1_q;
    logic [11:0] ctrl_q, ctrl_d;
    logic [7:0]  joy_p1, joy_p2;
    logic        key_evt, pressed, ext;
    logic        coin_raw, coin_req_q;
    coin_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        joy_hi_unused;

    assign joy_hi_unused = ^{joystick_0[15:8], joystick_1[15:8]};

    assign key_evt = primed_q && (ps2_key[10] != toggle_q);
    assign pressed = ps2_key[9];
    assign ext     = ps2_key[8];

    always_comb begin
        keys_d = keys_q;
        if (key_evt) begin
            case (ps2_key[7:0])
                8'h75: keys_d[11] = pressed;
                8'h72: keys_d[10] = pressed;
                8'h6B: keys_d[9]  = pressed;
                8'h74: keys_d[8]  = pressed;
                default: begin
                    if (!ext) begin
                        case (ps2_key[7:0])
                            8'h29, 8'h14: keys_d[7]  = pressed;
                            8'h2D:        keys_d[6]  = pressed;
                            8'h2B:        keys_d[5]  = pressed;
                            8'h23:        keys_d[4]  = pressed;
                            8'h34:        keys_d[3]  = pressed;
                            8'h1C:        keys_d[2]  = pressed;
                            8'h05, 8'h16: keys_d[1]  = pressed;
                            8'h06, 8'h1E: keys_d[0]  = pressed;
                            8'h2E:        keys_d[12] = pressed;
                            8'h36:        keys_d[13] = pressed;
                            default:      ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Cocktail gives each pad its own player; upright lets either pad drive both.
    assign joy_p1 = cocktail ? joy0_q : (joy0_q | joy1_q);
    assign joy_p2 = cocktail ? joy1_q : (joy0_q | joy1_q);

    always_comb begin
        ctrl_d = {keys_q[11] | joy_p1[3], keys_q[10] | joy_p1[2],
                  keys_q[9]  | joy_p1[1], keys_q[8]  | joy_p1[0],
                  keys_q[7]  | joy_p1[4],
                  keys_q[6]  | joy_p2[3], keys_q[5]  | joy_p2[2],
                  keys_q[4]  | joy_p2[1], keys_q[3]  | joy_p2[0],
                  keys_q[2]  | joy_p2[4],
                  keys_q[1]  | joy0_q[5] | joy1_q[5],
                  keys_q[0]  | joy0_q[6] | joy1_q[6]};
    end

    assign coin_raw = keys_q[12] | keys_q[13] | joy0_q[7] | joy1_q[7];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (coin_raw && !coin_req_q) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed_q   <= 1'b0;
            toggle_q   <= 1'b0;
            keys_q     <= '0;
            joy0_q     <= '0;
            joy1_q     <= '0;
            ctrl_q     <= '0;
            coin_req_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
        end else begin
            primed_q   <= 1'b1;
            toggle_q   <= ps2_key[10];
            keys_q     <= keys_d;
            joy0_q     <= joystick_0[7:0];
            joy1_q     <= joystick_1[7:0];
            ctrl_q     <= ctrl_d;
            coin_req_q <= coin_raw;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign {up1, down1, left1, right1, fire1,
            up2, down2, left2, right2, fire2,
            start1, start2} = ctrl_q;
    assign coin1 = (state_q == S_PULSE);

endmodule

// File: tb/tb_berzerk_input_ctrl.sv
// tb/tb_berzerk_input_ctrl.sv - table-driven and scoreboarded bench for berzerk_input_ctrl
module tb_berzerk_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        cocktail;
    logic up1, down1, left1, right1, fire1, up2, down2, left2, right2, fire2;
    logic start1, start2, coin1;
    logic [11:0] outs;

    berzerk_input_ctrl #(.COIN_PULSE(8), .COIN_GAP(4), .CNT_W(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .cocktail(cocktail),
        .up1(up1), .down1(down1), .left1(left1), .right1(right1), .fire1(fire1),
        .up2(up2), .down2(down2), .left2(left2), .right2(right2), .fire2(fire2),
        .start1(start1), .start2(start2), .coin1(coin1)
    );

    always #5 clk_sys = ~clk_sys;

    assign outs = {up1, down1, left1, right1, fire1, up2, down2, left2, right2, fire2, start1, start2};

    typedef struct {
        string name;
        int    val;
    } exp_t;

    typedef struct {
        bit          evt;
        bit          pr;
        bit          ext;
        logic [7:0]  code;
        logic [15:0] j0;
        logic [15:0] j1;
        bit          ck;
        logic [11:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    bit   tog;

    task automatic expect_val(input string name, input int v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check(input int act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=0x%0h", act);
        end else begin
            e = sb.pop_front();
            if (act != e.val) begin
                bad++;
                $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic add(input bit evt, input bit pr, input bit ext, input logic [7:0] code,
                       input logic [15:0] j0, input logic [15:0] j1, input bit ck,
                       input logic [11:0] exp);
        vec_t v;
        v.evt = evt; v.pr = pr; v.ext = ext; v.code = code;
        v.j0 = j0; v.j1 = j1; v.ck = ck; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic send_key(input bit pr, input bit ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, pr, ext, code};
    endtask

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Counts coin1 samples over n cycles with no new stimulus.
    task automatic coin_window(input int n, output int highs, output int first, output int rises);
        bit prev;
        prev = 1'b0; highs = 0; first = -1; rises = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (coin1) begin
                highs++;
                if (first < 0) first = i;
                if (!prev) rises++;
            end
            prev = coin1;
        end
    endtask

    initial begin
        int highs, first, rises;
        bit prev;

        add(1,0,0,8'h29, 16'h0,16'h0,0, 12'h000);
        add(1,1,1,8'h75, 16'h0,16'h0,0, 12'h800);
        add(1,0,0,8'h75, 16'h0,16'h0,0, 12'h000);
        add(1,1,1,8'h29, 16'h0,16'h0,0, 12'h000);
        add(1,1,0,8'h14, 16'h0,16'h0,0, 12'h080);
        add(1,0,0,8'h29, 16'h0,16'h0,0, 12'h000);
        add(1,1,0,8'h2D, 16'h0,16'h0,0, 12'h040);
        add(1,1,0,8'h16, 16'h0,16'h0,0, 12'h042);
        add(1,0,0,8'h2D, 16'h0,16'h0,0, 12'h002);
        add(1,0,0,8'h05, 16'h0,16'h0,0, 12'h000);
        add(1,1,0,8'h06, 16'h0,16'h0,0, 12'h001);
        add(1,0,0,8'h1E, 16'h0,16'h0,0, 12'h000);
        add(0,0,0,8'h00, 16'h0000,16'h0010,1, 12'h004);
        add(0,0,0,8'h00, 16'h0000,16'h0010,0, 12'h084);
        add(0,0,0,8'h00, 16'h0009,16'h0000,1, 12'h900);
        add(0,0,0,8'h00, 16'h0009,16'h0000,0, 12'h948);
        add(1,1,0,8'h2B, 16'h0000,16'h0060,1, 12'h023);
        add(1,0,0,8'h2B, 16'h0000,16'h0002,1, 12'h010);
        add(1,1,0,8'h6B, 16'h0,16'h0,1, 12'h200);
        add(1,0,1,8'h6B, 16'h0,16'h0,1, 12'h000);
        add(1,1,0,8'h72, 16'h0,16'h0,1, 12'h400);
        add(1,1,1,8'h74, 16'h0,16'h0,1, 12'h500);
        add(1,0,0,8'h72, 16'h0,16'h0,1, 12'h100);
        add(1,0,0,8'h74, 16'h0,16'h0,1, 12'h000);
        add(1,1,0,8'h23, 16'h0,16'h0,1, 12'h010);
        add(1,1,0,8'h34, 16'h0,16'h0,1, 12'h018);
        add(1,1,0,8'h1C, 16'h0,16'h0,1, 12'h01C);
        add(1,1,1,8'h2D, 16'h0,16'h0,1, 12'h01C);
        add(1,0,0,8'h23, 16'h0,16'h0,1, 12'h00C);
        add(1,0,0,8'h34, 16'h0,16'h0,1, 12'h004);
        add(1,0,0,8'h1C, 16'h0,16'h0,1, 12'h000);

        reset = 1'b1;
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
        joystick_0 = '0;
        joystick_1 = '0;
        cocktail = 1'b0;
        repeat (2) @(negedge clk_sys);
        expect_val("reset_ctrl", 0);  check(int'(outs));
        expect_val("reset_coin", 0);  check(int'(coin1));

        // Stale toggle at reset release must not replay the pressed space key.
        reset = 1'b0;
        repeat (3) step();
        expect_val("stale_toggle_fire1", 0);  check(int'(fire1));
        send_key(1, 0, 8'h29);
        step();
        expect_val("key_lat_edge1", 0);  check(int'(fire1));
        step();
        expect_val("key_lat_edge2", 1);  check(int'(fire1));

        foreach (tbl[r]) begin
            if (tbl[r].evt) send_key(tbl[r].pr, tbl[r].ext, tbl[r].code);
            joystick_0 = tbl[r].j0;
            joystick_1 = tbl[r].j1;
            cocktail = tbl[r].ck;
            expect_val($sformatf("vec%0d", r), int'(tbl[r].exp));
            step();
            step();
            check(int'(outs));
        end

        // Back-to-back events: both applied, in order.
        send_key(1, 1, 8'h75); step();
        send_key(1, 0, 8'h2D); step();
        expect_val("consec_first", 12'h800);  check(int'(outs));
        step();
        expect_val("consec_both", 12'h840);  check(int'(outs));
        send_key(1, 0, 8'h75); step();
        send_key(0, 0, 8'h75); step();
        expect_val("press_release_mid", 12'h840);  check(int'(outs));
        step();
        expect_val("press_release_end", 12'h040);  check(int'(outs));
        send_key(0, 0, 8'h2D); step(); step();

        // Joystick coin held for 50 cycles yields a single 8-cycle pulse.
        joystick_0 = 16'h0080;
        expect_val("joy_coin_highs", 8);
        expect_val("joy_coin_first", 1);
        expect_val("joy_coin_rises", 1);
        coin_window(50, highs, first, rises);
        check(highs); check(first); check(rises);
        joystick_0 = '0;
        repeat (20) step();

        // Re-press inside GAP is dropped.
        expect_val("lock_highs", 8);
        expect_val("lock_first", 1);
        expect_val("lock_rises", 1);
        prev = 1'b0; highs = 0; first = -1; rises = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) send_key(1, 0, 8'h2E);
            if (i == 2) send_key(0, 0, 8'h2E);
            if (i == 9) send_key(1, 0, 8'h2E);
            step();
            if (coin1) begin
                highs++;
                if (first < 0) first = i;
                if (!prev) rises++;
            end
            prev = coin1;
        end
        check(highs); check(first); check(rises);
        send_key(0, 0, 8'h2E);
        repeat (10) step();
        send_key(1, 0, 8'h2E);
        expect_val("repress_highs", 8);
        expect_val("repress_first", 1);
        coin_window(20, highs, first, rises);
        check(highs); check(first);
        send_key(0, 0, 8'h2E);
        repeat (20) step();

        // Reset during the pulse drops coin1 at once; held key must not retrigger.
        send_key(1, 0, 8'h2E);
        repeat (4) step();
        expect_val("pulse_cycle3", 1);  check(int'(coin1));
        #2 reset = 1'b1;
        #1;
        expect_val("reset_async_coin", 0);  check(int'(coin1));
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        expect_val("held_after_reset", 0);
        coin_window(20, highs, first, rises);
        check(highs);
        send_key(0, 0, 8'h2E); step();
        send_key(1, 0, 8'h2E);
        expect_val("after_reset_highs", 8);
        expect_val("after_reset_first", 1);
        coin_window(20, highs, first, rises);
        check(highs); check(first);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/berzerk_input_ctrl.md
# berzerk_input_ctrl

Player-input front end for the Berzerk core, sitting between the HPS I/O block and the `berzerk` game module. It turns PS/2 key events and the two MiSTer joystick words into registered per-player controls, start and coin lines. Joystick routing depends on upright or cocktail cabinet mode. The coin request is converted into a fixed-width, debounced pulse.

## Interface
Parameters:
- `COIN_PULSE`, default 400000: coin1 high time in clk_sys cycles (10 ms at 40 MHz). Legal range is 1 to 2^CNT_W-1.
- `COIN_GAP`, default 400000: forced low time after each pulse before a new coin is accepted. Legal range is 1 to 2^CNT_W-1.
- `CNT_W`, default 20: width of the coin counter.

Ports:
- `clk_sys` in 1: system clock (40 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
- `joystick_0` in 16: pad 0. Bits: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2, [7] coin.
- `joystick_1` in 16: pad 1, same bit map.
- `cocktail` in 1: 1 selects cocktail routing.
- `up1`, `down1`, `left1`, `right1`, `fire1` out 1 each: player-1 controls, active-high.
- `up2`, `down2`, `left2`, `right2`, `fire2` out 1 each: player-2 controls, active-high.
- `start1`, `start2` out 1 each: start buttons.
- `coin1` out 1: stretched coin pulse.

## Operation
**Event detection**
- A `toggle_q` register holds the last sampled ps2_key[10].
- An event fires in a cycle when `primed`=1 and ps2_key[10] != toggle_q.
- `primed` clears on reset and sets on the first clock after reset. On that first clock `toggle_q` loads ps2_key[10] without firing an event, so a stale toggle is never replayed.

**Key table**
- Each event writes ps2_key[9] into the matching key flag. Unlisted codes are ignored.
- Arrow keys match any value of ps2_key[8]: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
- All other keys require ps2_key[8]=0:
  - 0x29 (space) and 0x14 (ctrl) share the P1 fire flag; the last event written wins.
  - 0x05 and 0x16 drive start1.
  - 0x06 and 0x1E drive start2.
  - 0x2E drives coin A; 0x36 drives coin B.
  - P2 keys: 0x2D up, 0x2B down, 0x23 left, 0x34 right, 0x1C fire.

**Joystick path**
- Both joystick words are registered once (`joy0_q`, `joy1_q`).
- Upright (`cocktail`=0): P1 = P1 keys | joy0_q | joy1_q, and P2 = P2 keys | joy0_q | joy1_q.
- Cocktail (`cocktail`=1): P1 = P1 keys | joy0_q, and P2 = P2 keys | joy1_q.
- start1 = key | joy0_q[5] | joy1_q[5]. start2 = key | joy0_q[6] | joy1_q[6].
- Raw coin = coinA | coinB | joy0_q[7] | joy1_q[7].

**Coin state machine** (`coin_req_q` holds raw coin registered; `cnt` is CNT_W bits)
- IDLE, coin1=0: a rising edge (raw=1 and coin_req_q=0) moves to PULSE with cnt=COIN_PULSE-1.
- PULSE, coin1=1: cnt decrements. At cnt=0, move to GAP with cnt=COIN_GAP-1.
- GAP, coin1=0: cnt decrements. At cnt=0, move to IDLE.
- Edges arriving in PULSE or GAP are discarded, not queued.
- Holding coin yields exactly one pulse. Another pulse needs release, then re-press after reaching IDLE.

**Reset**
- All outputs, key flags, joystick registers, `coin_req_q`, `toggle_q`, `primed` and `cnt` go to 0; the state machine goes to IDLE.
- Reset mid-pulse drops coin1 asynchronously.

## Timing
- Key path: an event sampled at edge k updates the key flag at edge k; the output register updates at edge k+1.
- Joystick path: the input is sampled at edge k and the output changes at edge k+1. Both paths therefore have the same 2-edge latency.
- `cocktail` is combinational into the output register, so a change takes effect at the next edge.
- Coin: raw coin rising at edge k (into `coin_req_q`) gives coin1=1 from edge k+1 for exactly COIN_PULSE cycles. coin1 then stays low for at least COIN_GAP cycles.
- A key event and a joystick change in the same cycle are both applied (OR); neither is lost.
- Two events in consecutive cycles (toggle flips every cycle) are each applied in order.

## Test plan
Bench parameters: COIN_PULSE=8, COIN_GAP=4, CNT_W=4.
- Reset release with ps2_key[10]=1 and code 0x029 pressed → fire1 stays 0. Then toggle to 0 with the same code and pressed=1 → fire1=1 two edges later.
- Arrow keys: code 0x175 pressed → up1=1. Code 0x075 released → up1=0. Code 0x129 (extended space) → no change on any output.
- Cocktail routing: joystick_1=0x0010 with cocktail=1 → fire2=1 and fire1=0. Switch cocktail to 0 → fire1=1 and fire2=1.
- Coin: joystick_0[7] held high for 50 cycles → coin1 high for exactly 8 cycles, then 0 for the remainder.
- Coin lockout: key 0x2E pressed, released after 2 cycles, pressed again 9 cycles after the first press (inside GAP) → only one pulse. Re-press after returning to IDLE → a second 8-cycle pulse.
- Reset asserted on cycle 3 of a pulse → coin1=0 immediately. After release with coin still held → no pulse until coin is released and pressed again.
